bus_arbiter: RTL and testbench

BUS_ARBITER -- requirements
Module: bus_arbiter

---
 rtl/bus_arbiter_if.sv | 57 +++++
 rtl/bus_arbiter.sv | 156 +++++++++++++++
 tb/tb_bus_arbiter.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// ---------------------------------------------------------------------------
// bus_arbiter_if
//   Bundle of every non-clock signal around bus_arbiter: the instruction
//   fetch port, the load/store port and the shared bus side.
//
//   modport master : the arbiter's view. It takes requests and bus
//                    responses, and drives completions and bus commands.
//   modport slave  : the surrounding system's view, with every direction
//                    reversed (CPU ports plus bus target).
//
//   Fetch     : instr_req, instr_addr -> instr_data, instr_ready
//   Load/store: data_read, data_write, data_addr, data_wdata, data_sel
//               -> data_rdata, data_ready
//   Bus       : bus_addr, bus_wdata, bus_sel, bus_read, bus_write, bus_err
//               <- bus_rdata, bus_busy
// ---------------------------------------------------------------------------
interface bus_arbiter_if;
  logic        instr_req;
  logic [31:0] instr_addr;
  logic [31:0] instr_data;
  logic        instr_ready;

  logic        data_read;
  logic        data_write;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_sel;
  logic [31:0] data_rdata;
  logic        data_ready;

  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_sel;
  logic        bus_read;
  logic        bus_write;
  logic [31:0] bus_rdata;
  logic        bus_busy;
  logic        bus_err;

  modport master (
    input  instr_req, instr_addr,
    input  data_read, data_write, data_addr, data_wdata, data_sel,
    input  bus_rdata, bus_busy,
    output instr_data, instr_ready,
    output data_rdata, data_ready,
    output bus_addr, bus_wdata, bus_sel, bus_read, bus_write, bus_err
  );

  modport slave (
    output instr_req, instr_addr,
    output data_read, data_write, data_addr, data_wdata, data_sel,
    output bus_rdata, bus_busy,
    input  instr_data, instr_ready,
    input  data_rdata, data_ready,
    input  bus_addr, bus_wdata, bus_sel, bus_read, bus_write, bus_err
  );
endinterface

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
//   Shares a single bus between an instruction-fetch port and a load/store
//   port. At most one transaction is in flight at a time.
//   The IDLE -> ISSUE -> WAIT sequence works as follows:
//     IDLE  : grant a request. Data beats fetch. A grant latches the owner,
//             the operation and the address/wdata/sel fields.
//     ISSUE : the bus_read or bus_write strobe is high for this one cycle.
//     WAIT  : hold while bus_busy is high. When busy drops, complete the
//             transaction. If busy stays high for MAX_WAIT cycles, end with
//             a timeout: ready with rdata=0, plus bus_err.
//   Every output is registered.
//
// Parameters
//   MAX_WAIT : number of busy cycles in WAIT before a timeout (1..255)
// Ports
//   clk : system clock, rising edge
//   rst : asynchronous active-high reset. Drops any in-flight transaction.
//   io  : bus_arbiter_if.master, carrying the request, completion and bus
//         signals
// ---------------------------------------------------------------------------
module bus_arbiter #(
  parameter int MAX_WAIT = 255
) (
  input  logic           clk,
  input  logic           rst,
  bus_arbiter_if.master  io
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  state_t      state;
  logic [7:0]  wait_cnt;
  logic        own_data;   // 1: the load/store port owns the bus, 0: fetch
  logic        op_write;   // latched operation; a store leaves data_rdata alone

  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  sel_q;
  logic        bus_read_q;
  logic        bus_write_q;
  logic        bus_err_q;
  logic [31:0] instr_data_q;
  logic        instr_ready_q;
  logic [31:0] data_rdata_q;
  logic        data_ready_q;

  // A requester keeps its request high through the cycle its ready is high.
  // The request is masked during that cycle, so it is not served twice.
  logic data_go;
  logic instr_go;
  assign data_go  = (io.data_read | io.data_write) & ~data_ready_q;
  assign instr_go = io.instr_req & ~instr_ready_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      wait_cnt      <= 8'd0;
      own_data      <= 1'b0;
      op_write      <= 1'b0;
      addr_q        <= 32'd0;
      wdata_q       <= 32'd0;
      sel_q         <= 4'd0;
      bus_read_q    <= 1'b0;
      bus_write_q   <= 1'b0;
      bus_err_q     <= 1'b0;
      instr_data_q  <= 32'd0;
      instr_ready_q <= 1'b0;
      data_rdata_q  <= 32'd0;
      data_ready_q  <= 1'b0;
    end else begin
      // Strobes and pulses default low, so none can last two cycles.
      bus_read_q    <= 1'b0;
      bus_write_q   <= 1'b0;
      bus_err_q     <= 1'b0;
      instr_ready_q <= 1'b0;
      data_ready_q  <= 1'b0;

      unique case (state)
        IDLE: begin
          if (data_go) begin
            // If read and write are both high, the request is a write.
            own_data    <= 1'b1;
            op_write    <= io.data_write;
            addr_q      <= io.data_addr;
            wdata_q     <= io.data_wdata;
            sel_q       <= io.data_sel;
            bus_write_q <= io.data_write;
            bus_read_q  <= ~io.data_write;
            state       <= ISSUE;
          end else if (instr_go) begin
            own_data    <= 1'b0;
            op_write    <= 1'b0;
            addr_q      <= io.instr_addr;
            wdata_q     <= 32'd0;
            sel_q       <= 4'hF;
            bus_read_q  <= 1'b1;
            state       <= ISSUE;
          end
        end

        // The strobe raised at grant is visible during this one cycle.
        ISSUE: begin
          wait_cnt <= 8'd0;
          state    <= WAIT;
        end

        WAIT: begin
          if (!io.bus_busy) begin
            if (own_data) begin
              data_ready_q <= 1'b1;
              if (!op_write) data_rdata_q <= io.bus_rdata;
            end else begin
              instr_ready_q <= 1'b1;
              instr_data_q  <= io.bus_rdata;
            end
            state <= IDLE;
          end else if (wait_cnt == WAIT_LAST) begin
            // This is the MAX_WAIT-th busy cycle, so give up on the bus.
            bus_err_q <= 1'b1;
            if (own_data) begin
              data_ready_q <= 1'b1;
              data_rdata_q <= 32'd0;
            end else begin
              instr_ready_q <= 1'b1;
              instr_data_q  <= 32'd0;
            end
            state <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign io.bus_addr    = addr_q;
  assign io.bus_wdata   = wdata_q;
  assign io.bus_sel     = sel_q;
  assign io.bus_read    = bus_read_q;
  assign io.bus_write   = bus_write_q;
  assign io.bus_err     = bus_err_q;
  assign io.instr_data  = instr_data_q;
  assign io.instr_ready = instr_ready_q;
  assign io.data_rdata  = data_rdata_q;
  assign io.data_ready  = data_ready_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed test of bus_arbiter with MAX_WAIT=4. Inputs are driven and
// outputs are sampled on the falling edge.
module tb_bus_arbiter;
  logic clk;
  logic rst;
  int   n_chk;
  int   n_fail;

  bus_arbiter_if bif();

  bus_arbiter #(.MAX_WAIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .io  (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst = 1'b1;
    bif.instr_req = 0; bif.instr_addr = 0;
    bif.data_read = 0; bif.data_write = 0;
    bif.data_addr = 0; bif.data_wdata = 0; bif.data_sel = 0;
    bif.bus_rdata = 0; bif.bus_busy = 0;

    // Reset state
    step(2);
    chk("rst_bus_read", bif.bus_read, 0);
    chk("rst_bus_addr", bif.bus_addr, 0);
    chk("rst_bus_sel", bif.bus_sel, 0);
    chk("rst_rdy", {bif.instr_ready, bif.data_ready, bif.bus_err}, 0);
    rst = 1'b0;

    // Fetch with minimum latency
    bif.instr_req = 1; bif.instr_addr = 32'h40; bif.bus_rdata = 32'h13;
    step();                                   // edge N: grant
    chk("f_bus_read", bif.bus_read, 1);
    chk("f_bus_addr", bif.bus_addr, 32'h40);
    chk("f_bus_sel", bif.bus_sel, 4'hF);
    chk("f_bus_write", bif.bus_write, 0);
    step();                                   // WAIT
    chk("f_strobe_once", bif.bus_read, 0);
    chk("f_early_rdy", bif.instr_ready, 0);
    step();                                   // ready
    chk("f_instr_ready", bif.instr_ready, 1);
    chk("f_instr_data", bif.instr_data, 32'h13);
    chk("f_data_ready", bif.data_ready, 0);
    step();                                   // request still held this edge
    chk("f_no_regrant", bif.bus_read, 0);
    chk("f_rdy_pulse", bif.instr_ready, 0);
    bif.instr_req = 0;
    step();

    // Contention: data served first, then the fetch
    bif.instr_req = 1; bif.data_read = 1; bif.data_addr = 32'h100;
    bif.data_sel = 4'hF; bif.bus_rdata = 32'hAAAA0001;
    step();                                   // N
    chk("c_bus_addr", bif.bus_addr, 32'h100);
    chk("c_bus_read", bif.bus_read, 1);
    step(2);                                  // N+2 edge -> data_ready
    chk("c_data_ready", bif.data_ready, 1);
    chk("c_data_rdata", bif.data_rdata, 32'hAAAA0001);
    chk("c_instr_ready0", bif.instr_ready, 0);
    bif.data_read = 0; bif.bus_rdata = 32'h13;
    step();                                   // fetch granted in the ready cycle
    chk("c_f_bus_read", bif.bus_read, 1);
    chk("c_f_bus_addr", bif.bus_addr, 32'h40);
    chk("c_data_ready_pulse", bif.data_ready, 0);
    step();
    chk("c_instr_ready_early", bif.instr_ready, 0);
    step();
    chk("c_instr_ready", bif.instr_ready, 1);
    chk("c_instr_data", bif.instr_data, 32'h13);
    bif.instr_req = 0;
    step();

    // Store with 3 busy cycles; requester inputs change after grant
    bif.data_write = 1; bif.data_addr = 32'h200; bif.data_wdata = 32'hDEADBEEF;
    bif.data_sel = 4'b0011; bif.bus_busy = 1; bif.bus_rdata = 32'h12345678;
    step();
    chk("s_bus_write", bif.bus_write, 1);
    chk("s_bus_read", bif.bus_read, 0);
    chk("s_bus_addr", bif.bus_addr, 32'h200);
    chk("s_bus_wdata", bif.bus_wdata, 32'hDEADBEEF);
    chk("s_bus_sel", bif.bus_sel, 4'b0011);
    bif.data_addr = 32'h999; bif.data_wdata = 32'h0; bif.data_sel = 4'hF;
    step();                                   // WAIT entered
    chk("s_write_once", bif.bus_write, 0);
    chk("s_addr_held", bif.bus_addr, 32'h200);
    chk("s_wdata_held", bif.bus_wdata, 32'hDEADBEEF);
    step(3);                                  // three busy cycles
    chk("s_no_rdy_busy", bif.data_ready, 0);
    chk("s_no_err", bif.bus_err, 0);
    chk("s_no_rewrite", bif.bus_write, 0);
    bif.bus_busy = 0;
    step();
    chk("s_data_ready", bif.data_ready, 1);
    chk("s_rdata_kept", bif.data_rdata, 32'hAAAA0001);
    chk("s_err0", bif.bus_err, 0);
    bif.data_write = 0;
    step();

    // Read and write both high: the request is a store
    bif.data_read = 1; bif.data_write = 1; bif.data_addr = 32'h240;
    step();
    chk("rw_bus_write", bif.bus_write, 1);
    chk("rw_bus_read", bif.bus_read, 0);
    step(2);
    chk("rw_data_ready", bif.data_ready, 1);
    bif.data_read = 0; bif.data_write = 0;
    step();

    // Timeout on a load: MAX_WAIT=4 busy cycles
    bif.data_read = 1; bif.data_addr = 32'h300; bif.bus_busy = 1; bif.bus_rdata = 32'h55;
    step(2);                                  // ISSUE, then WAIT
    step(3);                                  // 3 busy cycles
    chk("t_no_rdy_yet", bif.data_ready, 0);
    chk("t_no_err_yet", bif.bus_err, 0);
    step();                                   // 4th busy cycle -> timeout
    chk("t_data_ready", bif.data_ready, 1);
    chk("t_bus_err", bif.bus_err, 1);
    chk("t_rdata_zero", bif.data_rdata, 0);
    bif.data_read = 0; bif.bus_busy = 0;
    step();
    chk("t_err_pulse", bif.bus_err, 0);
    chk("t_rdy_pulse", bif.data_ready, 0);
    bif.instr_req = 1; bif.instr_addr = 32'h44;
    step();                                   // IDLE again: fetch granted
    chk("t_idle_grant", bif.bus_read, 1);
    chk("t_idle_addr", bif.bus_addr, 32'h44);
    step(2);
    chk("t_f_ready", bif.instr_ready, 1);
    chk("t_f_data", bif.instr_data, 32'h55);
    bif.instr_req = 0;
    step();

    // Reset in the middle of WAIT
    bif.data_read = 1; bif.data_addr = 32'h400; bif.bus_busy = 1; bif.bus_rdata = 32'h77;
    step(2);                                  // in WAIT
    #2 rst = 1'b1;
    #1;
    chk("r_bus_addr", bif.bus_addr, 0);
    chk("r_instr_data", bif.instr_data, 0);
    chk("r_bus_sel", bif.bus_sel, 0);
    chk("r_pulses", {bif.bus_read, bif.bus_write, bif.data_ready, bif.bus_err}, 0);
    bif.bus_busy = 0;
    step();
    rst = 1'b0;
    step();                                   // first edge after release: grant
    chk("r_no_ready", bif.data_ready, 0);
    chk("r_regrant", bif.bus_read, 1);
    chk("r_regrant_addr", bif.bus_addr, 32'h400);
    step(2);
    chk("r_ready", bif.data_ready, 1);
    chk("r_rdata", bif.data_rdata, 32'h77);
    bif.data_read = 0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
